irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer.sv | 139 +++++++++++++
 tb/tb_irq_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: takes a level interrupt from the timer into a 5-stage
// pipeline. It waits for a clean ID stage, flushes IF/ID, vectors the PC,
// writes the return address to $26 through the register-file port, and then
// holds in_isr until eret.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   irq_req, kernel   interrupt request; interrupts are masked while kernel=1
//   pc_if, pc_id      PCs of the IF and ID stage instructions
//   id_valid          ID stage holds a real instruction
//   id_is_ctrl        ID instruction is a control transfer
//   hazard_stall      load-use stall active this cycle
//   wb_regwr          WB stage owns the register-file write port this cycle
//   eret              return from handler (only honoured in ISR)
//   flush_if/flush_id bubble the IF/ID and ID/EX registers at the next edge
//   pc_vec, pc_hold   PC_next overrides (vector / hold)
//   epc_we, epc_data  $26 write strobe and saved return address
//   in_isr, irq_ack   handler active, one-cycle acknowledge to the peripheral
module irq_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_req,
  input  logic        kernel,
  input  logic [31:0] pc_if,
  input  logic [31:0] pc_id,
  input  logic        id_valid,
  input  logic        id_is_ctrl,
  input  logic        hazard_stall,
  input  logic        wb_regwr,
  input  logic        eret,
  output logic        flush_if,
  output logic        flush_id,
  output logic        pc_vec,
  output logic        pc_hold,
  output logic        epc_we,
  output logic [31:0] epc_data,
  output logic        in_isr,
  output logic        irq_ack
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    TAKE = 3'd2,
    SAVE = 3'd3,
    ISR  = 3'd4
  } state_t;

  typedef struct packed {
    logic flush_if;
    logic flush_id;
    logic pc_vec;
    logic pc_hold;
    logic in_isr;
    logic irq_ack;
  } ctl_t;

  state_t          state;
  ctl_t            ctl;
  logic [PC_W-1:0] epc;

  // An interrupt may only be taken when no load-use stall is pending and
  // the ID stage does not hold a control transfer (its delay slot semantics
  // would be broken by re-executing from EPC).
  function automatic logic eligible(input logic stall, input logic valid,
                                    input logic is_ctrl);
    return !stall && !(valid && is_ctrl);
  endfunction

  // Next-state rules.
  function automatic state_t next_state(input state_t s);
    state_t n;
    n = s;
    case (s)
      IDLE: if (irq_req && !kernel)
              n = eligible(hazard_stall, id_valid, id_is_ctrl) ? TAKE : WAIT;
      WAIT: if (!irq_req) n = IDLE;
            else if (eligible(hazard_stall, id_valid, id_is_ctrl)) n = TAKE;
      TAKE: n = SAVE;
      SAVE: if (!wb_regwr) n = ISR;
      ISR:  if (eret) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Output pattern for the state being entered; registered alongside state.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      TAKE: begin
        c.flush_if = 1'b1;
        c.flush_id = 1'b1;
        c.pc_vec   = 1'b1;
        c.irq_ack  = 1'b1;
        c.in_isr   = 1'b1;
      end
      SAVE: begin
        c.flush_if = 1'b1;
        c.pc_hold  = 1'b1;
        c.in_isr   = 1'b1;
      end
      ISR:     c.in_isr = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // State, registered controls and EPC capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ctl   <= '0;
      epc   <= '0;
    end else begin
      state <= next_state(state);
      ctl   <= decode(next_state(state));
      // ID still holds its instruction during TAKE; the flush lands at this edge.
      if (state == TAKE) epc <= id_valid ? pc_id : pc_if;
    end
  end

  assign flush_if = ctl.flush_if;
  assign flush_id = ctl.flush_id;
  assign pc_vec   = ctl.pc_vec;
  assign pc_hold  = ctl.pc_hold;
  assign in_isr   = ctl.in_isr;
  assign irq_ack  = ctl.irq_ack;
  assign epc_data = epc;

  // WB's use of the write port is only known in the same cycle, so the $26
  // write strobe is decoded combinationally from SAVE; state resets
  // asynchronously, which also kills a pending write.
  assign epc_we = (state == SAVE) && !wb_regwr;

endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_req, kernel, id_valid, id_is_ctrl, hazard_stall, wb_regwr, eret;
  logic [31:0] pc_if, pc_id;
  logic        flush_if, flush_id, pc_vec, pc_hold, epc_we, in_isr, irq_ack;
  logic [31:0] epc_data;

  int total = 0;
  int bad   = 0;

  // Reference model: handler-progress flags and the saved return address.
  bit          m_wait, m_take, m_save, m_isr;
  logic [31:0] m_epc;

  irq_sequencer dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .kernel(kernel),
    .pc_if(pc_if), .pc_id(pc_id), .id_valid(id_valid), .id_is_ctrl(id_is_ctrl),
    .hazard_stall(hazard_stall), .wb_regwr(wb_regwr), .eret(eret),
    .flush_if(flush_if), .flush_id(flush_id), .pc_vec(pc_vec), .pc_hold(pc_hold),
    .epc_we(epc_we), .epc_data(epc_data), .in_isr(in_isr), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_take = 0; m_save = 0; m_isr = 0; m_epc = '0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ":flush_if"}, 32'(flush_if), 32'(m_take || m_save));
    chk({ctx, ":flush_id"}, 32'(flush_id), 32'(m_take));
    chk({ctx, ":pc_vec"},   32'(pc_vec),   32'(m_take));
    chk({ctx, ":pc_hold"},  32'(pc_hold),  32'(m_save));
    chk({ctx, ":irq_ack"},  32'(irq_ack),  32'(m_take));
    chk({ctx, ":in_isr"},   32'(in_isr),   32'(m_take || m_save || m_isr));
    chk({ctx, ":epc_we"},   32'(epc_we),   32'(m_save && !wb_regwr));
    chk({ctx, ":epc_data"}, epc_data,      m_epc);
  endtask

  // One clock of the reference behaviour, using the inputs seen at the edge.
  task automatic model_step();
    bit elig;
    elig = !hazard_stall && !(id_valid && id_is_ctrl);
    if (m_take) begin
      m_take = 0; m_save = 1;
      m_epc = id_valid ? pc_id : pc_if;
    end else if (m_save) begin
      if (!wb_regwr) begin m_save = 0; m_isr = 1; end
    end else if (m_isr) begin
      if (eret) m_isr = 0;
    end else if (m_wait) begin
      if (!irq_req) m_wait = 0;
      else if (elig) begin m_wait = 0; m_take = 1; end
    end else if (irq_req && !kernel) begin
      if (elig) m_take = 1; else m_wait = 1;
    end
  endtask

  // Caller sets inputs just after a rising edge; outputs checked on the falling edge.
  task automatic tick(input string ctx);
    @(negedge clk);
    check_outputs(ctx);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    irq_req = 0; kernel = 0; id_valid = 0; id_is_ctrl = 0; hazard_stall = 0;
    wb_regwr = 0; eret = 0; pc_if = 32'h0000_0100; pc_id = 32'h0000_00fc;
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_step(); #1;

    // Clean take with valid ID instruction: EPC from pc_id.
    irq_req = 1; id_valid = 1; pc_id = 32'h0000_0040; pc_if = 32'h0000_0044;
    tick("r20_idle");
    chk("r20_take_state", 32'(irq_ack & pc_vec & flush_if & flush_id), 32'd1);
    tick("r20_take");
    irq_req = 0;
    tick("r20_save");
    chk("r20_isr_in", 32'(in_isr), 32'd1);
    tick("r20_isr");
    eret = 1; tick("r20_eret"); eret = 0;
    tick("r20_back_idle");

    // Control instruction in ID delays the take for two cycles.
    irq_req = 1; id_valid = 1; id_is_ctrl = 1; pc_id = 32'h0000_0058;
    tick("r21_c0");
    tick("r21_c1");
    id_is_ctrl = 0;
    tick("r21_c2");
    irq_req = 0;
    tick("r21_take");
    chk("r21_epc", epc_data, 32'h0000_0058);

    // WB holds the write port for two SAVE cycles.
    wb_regwr = 1; tick("r22_s0");
    tick("r22_s1");
    wb_regwr = 0; tick("r22_s2");
    eret = 1; tick("r22_isr"); eret = 0;

    // Request during a load-use stall, withdrawn before eligibility.
    irq_req = 1; hazard_stall = 1; id_is_ctrl = 0;
    tick("r23_req");
    irq_req = 0;
    tick("r23_wait");
    hazard_stall = 0;
    tick("r23_idle");

    // eret and irq_req together in ISR: eret wins, request retaken from IDLE.
    irq_req = 1; id_valid = 0; pc_if = 32'h0000_0200;
    tick("r24_i0"); tick("r24_take"); tick("r24_save");
    eret = 1; kernel = 1; tick("r24_isr_eret");
    eret = 0; kernel = 0; tick("r24_idle");
    chk("r24_take_ack", 32'(irq_ack), 32'd1);
    irq_req = 0; tick("r24_take2");

    // Asynchronous reset while SAVE is waiting on the write port.
    wb_regwr = 1;
    @(negedge clk); #1;
    chk("r25_pre_save_hold", 32'(pc_hold), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("r25_epc_we", 32'(epc_we), 32'd0);
    chk("r25_epc_data", epc_data, 32'd0);
    check_outputs("r25_async");
    @(posedge clk); #1;
    check_outputs("r25_held");
    reset = 1'b1;
    wb_regwr = 0;
    @(posedge clk); model_step(); #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      irq_req      = ($urandom_range(0, 9) < 6);
      kernel       = ($urandom_range(0, 3) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_is_ctrl   = ($urandom_range(0, 3) == 0);
      hazard_stall = ($urandom_range(0, 4) == 0);
      wb_regwr     = $urandom_range(0, 1) == 1;
      eret         = ($urandom_range(0, 3) == 0);
      pc_if        = {$urandom() & 32'h7fff_fffc};
      pc_id        = {$urandom() & 32'h7fff_fffc};
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
